corelet_ctrl: RTL and testbench
===============================

# corelet_ctrl

Sequencing controller for the corelet. On a `start` pulse it runs one tile pass in either weight-stationary (WS) or output-stationary (OS) mode. It streams operands from activation/weight SRAM (xmem) into the L0/IFIFO buffers and drives the corelet's 8-bit `inst` word, `mode` and `output_en`. It then drains the OFIFO into psum SRAM (pmem). It sits between the top-level testbench/host and the corelet plus its two SRAMs.

## Interface
- `row`, default 8: MAC rows, which is the L0 width in lanes.
- `col`, default 8: MAC columns.
- `addr_bw`, default 11: xmem and pmem address width.
- `len_bw`, default 7: width of `cfg_len`.
- `clk`, input, 1: the single clock; every flop is rising-edge.
- `reset`, input, 1: synchronous, active-low reset.
- `start`, input, 1: pulse that begins a pass; sampled only in IDLE.
- `cfg_mode`, input, 1: 0 selects WS, 1 selects OS; latched at start.
- `cfg_acc`, input, 1: in WS, drive `inst[7]` during DRAIN; latched at start.
- `cfg_len`, input, `len_bw`: N, the number of activation vectors; latched at start.
- `cfg_a_base`, `cfg_w_base`, `cfg_p_base`, input, `addr_bw` each: activation, weight and psum base addresses; latched at start.
- `o_valid`, input, 1: corelet OFIFO has a full output vector.
- `inst`, output, 8: bits 7 to 0 are {acc, ofifo_rd, ififo_wr, ififo_rd, l0_rd, l0_wr, execute, kernel_load}.
- `mode`, output, 1: latched `cfg_mode`.
- `output_en`, output, 1: OS result shift-out enable.
- `xmem_cen_n`, output, 1: xmem chip enable, active low; read only.
- `xmem_addr`, output, `addr_bw`: xmem address.
- `pmem_cen_n`, output, 1: pmem chip enable, active low.
- `pmem_wen_n`, output, 1: pmem write enable, active low.
- `pmem_addr`, output, `addr_bw`: pmem address.
- `busy`, output, 1: high in any state other than IDLE.
- `done`, output, 1: one-cycle pulse at the end of a pass.

## Operation
- **Length rule:** latch N = `cfg_len`, saturated to 64 (the L0/IFIFO depth).
  - N = 0: go IDLE → DONE → IDLE with no memory or FIFO traffic.
- **xmem read latency is 1 cycle.**
  - A read issued in cycle t delivers data in cycle t+1.
  - The matching `l0_wr` or `ififo_wr` is asserted in t+1.
  - Every FILL phase therefore lasts (reads + 1) cycles; its last cycle asserts the write only.
- **WS sequence:**
  - W_FILL: read `cfg_w_base` + k for k = 0..row-1, with `l0_wr` one cycle delayed.
  - K_LOAD: `row` cycles with `l0_rd` = 1 and `kernel_load` = 1.
  - K_FLUSH: row + col cycles with `inst` = 0.
  - A_FILL: read `cfg_a_base` + k for k = 0..N-1, with `l0_wr` delayed.
  - EXEC: N cycles with `l0_rd` = 1 and `execute` = 1.
  - DRAIN: D = N vectors.
  - DONE, then IDLE.
- **OS sequence:**
  - A_FILL: N reads into L0 (`l0_wr`).
  - W_FILL: N reads from `cfg_w_base` + k into IFIFO (`ififo_wr`).
  - EXEC: N cycles with `l0_rd`, `ififo_rd` and `execute` all high.
  - OUT: `row` cycles with `output_en` = 1.
  - DRAIN: D = row vectors.
  - DONE, then IDLE.
- **DRAIN:**
  - In any cycle with `o_valid` = 1 and remaining > 0, assert `inst[6]` (ofifo_rd), `pmem_cen_n` = 0 and `pmem_wen_n` = 0.
  - In that cycle, `pmem_addr` = `cfg_p_base` + drained count.
  - Leave DRAIN after the D-th read.
  - `inst[7]` = `cfg_acc` & ~mode throughout DRAIN; it is 0 in every other state.
- **Addresses:** address arithmetic is modulo 2^`addr_bw` (wraps silently).
- **Ignored inputs:**
  - `start` outside IDLE is ignored.
  - `cfg_*` changes after start have no effect.
- **Reset:** reset asserted mid-pass returns the block to IDLE at the next edge and discards counters. The corelet FIFOs are reset by the same signal.

## Timing
- **Output registration:**
  - `inst[6]`, `pmem_cen_n`, `pmem_wen_n` and `pmem_addr` are combinational from `o_valid` and state. This prevents a double read on a registered `o_valid`.
  - All other outputs are registered.
- **Reset values:**
  - `inst` = 0, `mode` = 0, `output_en` = 0, `busy` = 0, `done` = 0.
  - `xmem_cen_n` = 1, `pmem_cen_n` = 1, `pmem_wen_n` = 1.
  - `xmem_addr` = 0, `pmem_addr` = 0.
- **Start latency:** `start` sampled high in cycle 0 gives `busy` = 1 and the first xmem read in cycle 1.
- **WS pass with a continuously valid OFIFO:** 1 + (row+1) + row + (row+col) + (N+1) + N + N + 1 cycles to `done`.
- **No overlap between phases:** no `l0_rd` is asserted before the last `l0_wr` of the preceding fill.
- **`done` pulse:** high for exactly one cycle. `busy` falls in the same cycle that `done` rises. A new `start` is accepted in the cycle after `done`.

## Test plan
- **WS, N = 4:**
  - Stimulus: start with `cfg_w_base` = 0, `cfg_a_base` = 16, `cfg_p_base` = 100, `o_valid` forced high in DRAIN.
  - Required: xmem addresses 0..7, then 16..19; 8 kernel_load cycles; 16 flush cycles; 4 execute cycles.
  - Required: pmem writes at 100..103; `done` exactly 1+9+8+16+5+4+4+1 cycles after start.
- **OS, N = 3:**
  - Required: `l0_wr` ×3, then `ififo_wr` ×3; 3 cycles with `inst` = 8'b0001_1010; 8 cycles with `output_en` = 1.
  - Required: exactly 8 pmem writes; `mode` = 1 throughout the pass.
- **DRAIN with `o_valid` toggling every other cycle, N = 4:**
  - Required: exactly 4 `ofifo_rd` pulses, each coincident with `o_valid` = 1; pmem addresses contiguous.
- **Edge cases:**
  - `cfg_len` = 0 gives `done` 2 cycles after start, with no `cen` activity.
  - `cfg_len` = 100 saturates, giving exactly 64 execute cycles.
- **Reset and start handling:**
  - Active-low `reset` pulsed during EXEC: all outputs take their reset values at the next edge, and a fresh start runs a complete pass.
  - `start` re-pulsed while `busy` is ignored.
- **WS with `cfg_acc` = 1:**
  - Required: `inst[7]` = 1 only during DRAIN.
  - Required: the same pass in OS mode keeps `inst[7]` = 0.

Source files
------------

// File: rtl/corelet_ctrl.sv
// corelet_ctrl: runs one WS/OS tile pass: xmem -> L0/IFIFO, corelet inst sequencing, OFIFO -> pmem
module corelet_ctrl #(
  parameter int row = 8,
  parameter int col = 8,
  parameter int addr_bw = 11,
  parameter int len_bw = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               cfg_mode,
  input  logic               cfg_acc,
  input  logic [len_bw-1:0]  cfg_len,
  input  logic [addr_bw-1:0] cfg_a_base,
  input  logic [addr_bw-1:0] cfg_w_base,
  input  logic [addr_bw-1:0] cfg_p_base,
  input  logic               o_valid,
  output logic [7:0]         inst,
  output logic               mode,
  output logic               output_en,
  output logic               xmem_cen_n,
  output logic [addr_bw-1:0] xmem_addr,
  output logic               pmem_cen_n,
  output logic               pmem_wen_n,
  output logic [addr_bw-1:0] pmem_addr,
  output logic               busy,
  output logic               done
);
  localparam int cw = 16;
  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_W_FILL  = 4'd1;
  localparam logic [3:0] S_K_LOAD  = 4'd2;
  localparam logic [3:0] S_K_FLUSH = 4'd3;
  localparam logic [3:0] S_A_FILL  = 4'd4;
  localparam logic [3:0] S_EXEC    = 4'd5;
  localparam logic [3:0] S_OUT     = 4'd6;
  localparam logic [3:0] S_DRAIN   = 4'd7;
  localparam logic [3:0] S_DONE    = 4'd8;

  logic [3:0]         state_q, state_d, nxt;
  logic [cw-1:0]      cnt_q, cnt_d, n_q, n_d, n_sat, plen, reads_d;
  logic               mode_q, mode_d, acc_q, acc_d;
  logic [addr_bw-1:0] a_base_q, a_base_d, w_base_q, w_base_d, p_base_q, p_base_d;
  logic [5:0]         ctl_q, ctl_d;
  logic               acc_o_q, acc_o_d, oen_q, oen_d, xcen_q, xcen_d, busy_q, busy_d, done_q, done_d;
  logic [addr_bw-1:0] xaddr_q, xaddr_d;
  logic               go, rd, last, fill_d, rd_x, wr_x, ifill_d;

  // configuration is captured only when a start is accepted from IDLE; length saturates at the L0/IFIFO depth
  assign go       = (state_q == S_IDLE) && start;
  assign n_sat    = (cw'(cfg_len) > cw'(64)) ? cw'(64) : cw'(cfg_len);
  assign n_d      = go ? n_sat : n_q;
  assign mode_d   = go ? cfg_mode : mode_q;
  assign acc_d    = go ? cfg_acc : acc_q;
  assign a_base_d = go ? cfg_a_base : a_base_q;
  assign w_base_d = go ? cfg_w_base : w_base_q;
  assign p_base_d = go ? cfg_p_base : p_base_q;

  // an OFIFO read happens on every valid cycle in DRAIN; DRAIN exits on the last one so remaining is never 0 here
  assign rd = (state_q == S_DRAIN) && o_valid;

  // length of the current phase in cycles (DRAIN: in reads); FILL phases are one longer than their read count
  assign plen = (state_q == S_W_FILL)  ? (mode_q ? n_q + cw'(1) : cw'(row + 1)) :
                (state_q == S_K_LOAD)  ? cw'(row) :
                (state_q == S_K_FLUSH) ? cw'(row + col) :
                (state_q == S_A_FILL)  ? n_q + cw'(1) :
                (state_q == S_EXEC)    ? n_q :
                (state_q == S_OUT)     ? cw'(row) :
                (state_q == S_DRAIN)   ? (mode_q ? cw'(row) : n_q) : cw'(1);
  assign last = (cnt_q == plen - cw'(1)) && ((state_q != S_DRAIN) || rd);

  // phase order: WS is W_FILL, K_LOAD, K_FLUSH, A_FILL, EXEC, DRAIN; OS is A_FILL, W_FILL, EXEC, OUT, DRAIN
  always_comb begin
    nxt = S_IDLE;
    case (state_q)
      S_W_FILL:  nxt = mode_q ? S_EXEC : S_K_LOAD;
      S_K_LOAD:  nxt = S_K_FLUSH;
      S_K_FLUSH: nxt = S_A_FILL;
      S_A_FILL:  nxt = mode_q ? S_W_FILL : S_EXEC;
      S_EXEC:    nxt = mode_q ? S_OUT : S_DRAIN;
      S_OUT:     nxt = S_DRAIN;
      S_DRAIN:   nxt = S_DONE;
      default:   nxt = S_IDLE;
    endcase
  end

  assign state_d = go ? ((n_sat == '0) ? S_DONE : (cfg_mode ? S_A_FILL : S_W_FILL)) :
                   (state_q == S_IDLE) ? S_IDLE : (last ? nxt : state_q);
  assign cnt_d   = ((state_q == S_IDLE) || last) ? '0 :
                   ((state_q == S_DRAIN) && !rd) ? cnt_q : cnt_q + cw'(1);

  // registered outputs are decoded from next state so they line up with the state they describe
  assign fill_d  = (state_d == S_W_FILL) || (state_d == S_A_FILL);
  assign ifill_d = (state_d == S_W_FILL) && mode_d;
  assign reads_d = ((state_d == S_W_FILL) && !mode_d) ? cw'(row) : n_d;
  assign rd_x    = fill_d && (cnt_d < reads_d);
  assign wr_x    = fill_d && (cnt_d != '0);
  assign xcen_d  = !rd_x;
  assign xaddr_d = rd_x ? (((state_d == S_W_FILL) ? w_base_d : a_base_d) + addr_bw'(cnt_d)) : '0;
  assign ctl_d   = {wr_x && ifill_d, (state_d == S_EXEC) && mode_d,
                    (state_d == S_K_LOAD) || (state_d == S_EXEC), wr_x && !ifill_d,
                    state_d == S_EXEC, state_d == S_K_LOAD};
  assign acc_o_d = (state_d == S_DRAIN) && acc_d && !mode_d;
  assign oen_d   = state_d == S_OUT;
  assign busy_d  = (state_d != S_IDLE) && (state_d != S_DONE);
  assign done_d  = state_d == S_DONE;

  // state, latched configuration and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      n_q      <= '0;
      mode_q   <= 1'b0;
      acc_q    <= 1'b0;
      a_base_q <= '0;
      w_base_q <= '0;
      p_base_q <= '0;
      ctl_q    <= '0;
      acc_o_q  <= 1'b0;
      oen_q    <= 1'b0;
      xcen_q   <= 1'b1;
      xaddr_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      n_q      <= n_d;
      mode_q   <= mode_d;
      acc_q    <= acc_d;
      a_base_q <= a_base_d;
      w_base_q <= w_base_d;
      p_base_q <= p_base_d;
      ctl_q    <= ctl_d;
      acc_o_q  <= acc_o_d;
      oen_q    <= oen_d;
      xcen_q   <= xcen_d;
      xaddr_q  <= xaddr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // OFIFO read and pmem write are combinational from o_valid so a registered valid is never read twice
  assign inst       = {acc_o_q, rd, ctl_q};
  assign mode       = mode_q;
  assign output_en  = oen_q;
  assign xmem_cen_n = xcen_q;
  assign xmem_addr  = xaddr_q;
  assign pmem_cen_n = !rd;
  assign pmem_wen_n = !rd;
  assign pmem_addr  = rd ? p_base_q + addr_bw'(cnt_q) : '0;
  assign busy       = busy_q;
  assign done       = done_q;
endmodule

// File: tb/tb_corelet_ctrl.sv
// tb_corelet_ctrl: scoreboard bench for corelet_ctrl against a pass-level reference model
module tb_corelet_ctrl;
  localparam int row = 8;
  localparam int col = 8;
  localparam int aw = 11;
  localparam int lw = 7;

  logic          clk = 1'b0, reset = 1'b0, start = 1'b0, cfg_mode = 1'b0, cfg_acc = 1'b0, o_valid = 1'b1;
  logic [lw-1:0] cfg_len = '0;
  logic [aw-1:0] cfg_a_base = '0, cfg_w_base = '0, cfg_p_base = '0;
  logic [7:0]    inst;
  logic          mode, output_en, xmem_cen_n, pmem_cen_n, pmem_wen_n, busy, done;
  logic [aw-1:0] xmem_addr, pmem_addr;

  int checks = 0, fails = 0, cyc = 0, npass = 0, vm = 0;

  typedef struct {
    bit os;
    int n;
    bit acc;
    int vm;
    int s0;
    int lat;
    int drain;
  } pass_t;

  pass_t         passq[$];
  logic [aw-1:0] xq[$];
  logic [aw-1:0] pq[$];

  corelet_ctrl #(.row(row), .col(col), .addr_bw(aw), .len_bw(lw)) dut (
    .clk(clk), .reset(reset), .start(start), .cfg_mode(cfg_mode), .cfg_acc(cfg_acc),
    .cfg_len(cfg_len), .cfg_a_base(cfg_a_base), .cfg_w_base(cfg_w_base), .cfg_p_base(cfg_p_base),
    .o_valid(o_valid), .inst(inst), .mode(mode), .output_en(output_en),
    .xmem_cen_n(xmem_cen_n), .xmem_addr(xmem_addr), .pmem_cen_n(pmem_cen_n),
    .pmem_wen_n(pmem_wen_n), .pmem_addr(pmem_addr), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic flag(input string nm);
    checks++;
    fails++;
    $display("FAIL %s: event occurred, expected none (cycle %0d)", nm, cyc);
  endtask

  task automatic chk_rst(input string nm);
    chk(nm, {inst, mode, output_en, busy, done, xmem_cen_n, pmem_cen_n, pmem_wen_n, xmem_addr, pmem_addr},
        {8'h00, 4'b0000, 3'b111, 22'd0});
  endtask

  // o_valid pattern: 0 = always high, 1 = toggle every cycle, 2 = random
  initial forever begin
    @(posedge clk);
    #1;
    o_valid = (vm == 0) ? 1'b1 : (vm == 1) ? ~o_valid : 1'($urandom_range(1));
  end

  // reference model: whole-pass expectations from the operation rules
  task automatic start_pass(input bit os, input int len, input logic [aw-1:0] a, input logic [aw-1:0] w,
                            input logic [aw-1:0] p, input bit acc, input int v);
    pass_t r;
    int n;
    n = (len > 64) ? 64 : len;
    vm = v;
    @(posedge clk);
    #1;
    cfg_mode = os; cfg_len = lw'(len); cfg_a_base = a; cfg_w_base = w; cfg_p_base = p; cfg_acc = acc;
    start = 1'b1;
    r.os = os; r.n = n; r.acc = acc; r.vm = v; r.s0 = cyc;
    r.drain = (n == 0) ? 0 : (os ? row : n);
    r.lat = (n == 0) ? 2 - 1 :
            os ? 1 + (n + 1) + (n + 1) + n + row + row + 1 - 1 :
                 1 + (row + 1) + row + (row + col) + (n + 1) + n + n + 1 - 1;
    if (n > 0) begin
      if (!os) for (int k = 0; k < row; k++) xq.push_back(w + aw'(k));
      for (int k = 0; k < n; k++) xq.push_back(a + aw'(k));
      if (os) for (int k = 0; k < n; k++) xq.push_back(w + aw'(k));
      for (int k = 0; k < r.drain; k++) pq.push_back(p + aw'(k));
    end
    passq.push_back(r);
    @(posedge clk);
    #1;
    start = 1'b0;
    cfg_mode = 1'($urandom_range(1)); cfg_acc = 1'($urandom_range(1)); cfg_len = lw'($urandom);
    cfg_a_base = aw'($urandom); cfg_w_base = aw'($urandom); cfg_p_base = aw'($urandom);
  endtask

  task automatic wait_done();
    int target;
    target = npass + 1;
    for (int i = 0; i < 3000 && npass < target; i++) @(posedge clk);
    if (npass < target) flag("done_timeout");
    @(posedge clk);
  endtask

  // monitor: consumes scoreboard entries as the DUT produces events
  int    kl, ex, l0w, ifw, oen, ofr, accn, osi, first_rd;
  bit    has;
  pass_t cur;
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      kl = 0; ex = 0; l0w = 0; ifw = 0; oen = 0; ofr = 0; accn = 0; osi = 0; first_rd = -1;
    end else begin
      has = passq.size() > 0;
      if (has) cur = passq[0];
      if (!has && (busy || !xmem_cen_n || !pmem_cen_n || inst != 8'h00 || output_en)) flag("activity_without_pass");
      if (!xmem_cen_n) begin
        if (first_rd < 0) first_rd = cyc;
        if (xq.size() == 0) flag("xmem_read_extra");
        else chk("xmem_addr", xmem_addr, xq.pop_front());
      end
      if (inst[6]) begin
        ofr++;
        chk("ofifo_rd_with_valid", o_valid, 1);
        chk("pmem_write_enables", {pmem_cen_n, pmem_wen_n}, 0);
        if (pq.size() == 0) flag("pmem_write_extra");
        else chk("pmem_addr", pmem_addr, pq.pop_front());
      end else if (!pmem_cen_n || !pmem_wen_n) flag("pmem_active_without_ofifo_rd");
      if (inst[2]) l0w++;
      if (inst[5]) begin
        ifw++;
        if (has) chk("ififo_wr_after_l0_fill", l0w, cur.n);
      end
      if (inst[3] && has) chk("l0_rd_after_fill", l0w, inst[0] ? row : (cur.os ? cur.n : row + cur.n));
      if (inst[4] && has) chk("ififo_rd_after_fill", ifw, cur.n);
      if (inst[0]) kl++;
      if (inst[1]) ex++;
      if (output_en) oen++;
      if (inst == 8'h1A) osi++;
      if (inst[7]) begin
        accn++;
        if (has) chk("acc_only_ws_acc", cur.acc && !cur.os, 1);
      end
      if (busy && has) chk("mode_latched", mode, cur.os);
      if (done) begin
        if (!has) flag("done_extra");
        else begin
          void'(passq.pop_front());
          chk("done_kernel_load", kl, (cur.os || cur.n == 0) ? 0 : row);
          chk("done_execute", ex, cur.n);
          chk("done_l0_wr", l0w, (cur.n == 0) ? 0 : (cur.os ? cur.n : row + cur.n));
          chk("done_ififo_wr", ifw, cur.os ? cur.n : 0);
          chk("done_output_en", oen, (cur.os && cur.n > 0) ? row : 0);
          chk("done_ofifo_rd", ofr, cur.drain);
          chk("done_os_exec_inst", osi, cur.os ? cur.n : 0);
          chk("done_busy_low", busy, 0);
          chk("done_xmem_left", xq.size(), 0);
          chk("done_pmem_left", pq.size(), 0);
          if (cur.vm == 0) begin
            chk("done_latency", cyc - cur.s0, cur.lat);
            chk("done_acc_cycles", accn, (cur.acc && !cur.os) ? cur.n : 0);
          end
          if (cur.n > 0) chk("first_read_latency", first_rd - cur.s0, 1);
        end
        kl = 0; ex = 0; l0w = 0; ifw = 0; oen = 0; ofr = 0; accn = 0; osi = 0; first_rd = -1;
        npass++;
      end
    end
  end

  initial begin
    int i;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_rst("reset_values");
    @(posedge clk);
    #1 reset = 1'b1;
    start_pass(1'b0, 4, 11'd16, 11'd0, 11'd100, 1'b0, 0);
    wait_done();
    start_pass(1'b1, 3, 11'd40, 11'd60, 11'd200, 1'b0, 0);
    wait_done();
    start_pass(1'b0, 4, 11'd300, 11'd310, 11'd500, 1'b0, 1);
    wait_done();
    start_pass(1'b0, 0, 11'd1, 11'd2, 11'd3, 1'b1, 0);
    wait_done();
    start_pass(1'b0, 100, 11'd1000, 11'd2044, 11'd2000, 1'b0, 0);
    wait_done();
    start_pass(1'b0, 5, 11'd700, 11'd720, 11'd740, 1'b1, 0);
    wait_done();
    start_pass(1'b1, 5, 11'd700, 11'd720, 11'd740, 1'b1, 0);
    wait_done();
    start_pass(1'b0, 6, 11'd50, 11'd60, 11'd70, 1'b0, 0);
    repeat (5) @(posedge clk);
    #1;
    start = 1'b1; cfg_mode = 1'b1; cfg_len = 7'd20;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done();
    start_pass(1'b0, 8, 11'd64, 11'd0, 11'd300, 1'b1, 0);
    for (i = 0; i < 500 && !inst[1]; i++) @(negedge clk);
    if (!inst[1]) flag("exec_timeout");
    @(posedge clk);
    #1 reset = 1'b0;
    xq.delete();
    pq.delete();
    passq.delete();
    @(posedge clk);
    @(negedge clk);
    chk_rst("reset_mid_pass");
    @(posedge clk);
    #1 reset = 1'b1;
    start_pass(1'b0, 8, 11'd64, 11'd0, 11'd300, 1'b1, 0);
    wait_done();
    for (int k = 0; k < 10; k++) begin
      start_pass(1'($urandom_range(1)), $urandom_range(70), aw'($urandom), aw'($urandom), aw'($urandom),
                 1'($urandom_range(1)), $urandom_range(2));
      wait_done();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
